ptr_access_unit: RTL and testbench

PTR_ACCESS_UNIT -- requirements
Module: ptr_access_unit

---
 rtl/ptr_access_unit_pkg.sv | 14 +
 rtl/ptr_bounds_check.sv | 19 +
 rtl/ptr_access_unit.sv | 108 ++++++++++
 tb/tb_ptr_access_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ptr_access_unit_pkg.sv
// ptr_access_unit_pkg: shared widths, FSM encoding and fault codes for the pointer access path.
package ptr_access_unit_pkg;
  localparam int LBID_W_DEF = 12;
  localparam int OFS_W_DEF = 16;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;
  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_OOB  = 2'd1;
  localparam logic [1:0] F_OVF  = 2'd2;
  localparam logic [1:0] F_TMO  = 2'd3;
endpackage

// File: rtl/ptr_bounds_check.sv
// ptr_bounds_check: bounds test then carry test on base+ofs; bounds fault takes priority.
module ptr_bounds_check
  import ptr_access_unit_pkg::*;
#(
  parameter int OFS_W = OFS_W_DEF
) (
  input  logic [OFS_W-1:0] base,
  input  logic [OFS_W-1:0] size,
  input  logic [OFS_W-1:0] ofs,
  output logic [1:0]       fault,
  output logic [OFS_W-1:0] addr
);
  logic [OFS_W:0] sum;
  always_comb begin
    sum   = {1'b0, base} + {1'b0, ofs};
    addr  = sum[OFS_W-1:0];
    fault = (ofs >= size) ? F_OOB : sum[OFS_W] ? F_OVF : F_NONE;
  end
endmodule

// File: rtl/ptr_access_unit.sv
// ptr_access_unit: label lookup, bounds check and single memory access for a tagged pointer.
module ptr_access_unit
  import ptr_access_unit_pkg::*;
#(
  parameter int LBID_W = LBID_W_DEF,
  parameter int OFS_W  = OFS_W_DEF,
  parameter int DATA_W = 32,
  parameter int TMO    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [LBID_W-1:0] req_lbid,
  input  logic [OFS_W-1:0]  req_ofs,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [LBID_W-1:0] lbl_addr,
  input  logic [OFS_W-1:0]  lbl_base,
  input  logic [OFS_W-1:0]  lbl_size,
  output logic              mem_req,
  output logic              mem_we,
  output logic [OFS_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_fault
);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  logic [2:0]        state;
  logic              we;
  logic [LBID_W-1:0] lbid;
  logic [OFS_W-1:0]  ofs;
  logic [DATA_W-1:0] wdata;
  logic [CW-1:0]     cnt;
  logic [OFS_W-1:0]  addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        fault_q;
  logic [1:0]        chk_fault;
  logic [OFS_W-1:0]  chk_addr;

  ptr_bounds_check #(.OFS_W(OFS_W)) u_chk (
    .base  (lbl_base),
    .size  (lbl_size),
    .ofs   (ofs),
    .fault (chk_fault),
    .addr  (chk_addr)
  );

  assign req_ready = state == ST_IDLE;
  assign lbl_addr  = lbid;
  assign mem_req   = state == ST_MEM;
  assign mem_we    = mem_req & we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;
  assign rsp_valid = state == ST_RESP;
  assign rsp_data  = rdata_q;
  assign rsp_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      we      <= 1'b0;
      lbid    <= '0;
      ofs     <= '0;
      wdata   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= F_NONE;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          we      <= req_we;
          lbid    <= req_lbid;
          ofs     <= req_ofs;
          wdata   <= req_wdata;
          rdata_q <= '0;
          fault_q <= F_NONE;
          state   <= ST_LOOKUP;
        end
        ST_LOOKUP: state <= ST_CHECK;
        ST_CHECK: begin
          if (chk_fault == F_NONE) addr_q <= chk_addr;
          fault_q <= chk_fault;
          cnt     <= '0;
          state   <= (chk_fault == F_NONE) ? ST_MEM : ST_RESP;
        end
        ST_MEM: begin
          // an ack in the final counted cycle still completes normally
          if (mem_ack) begin
            rdata_q <= we ? '0 : mem_rdata;
            state   <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            fault_q <= F_TMO;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ptr_access_unit.sv
// tb_ptr_access_unit: directed scenarios with hand-computed expectations and a label-table model.
module tb_ptr_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_lbid = '0;
  logic [15:0] req_ofs = '0;
  logic [31:0] req_wdata = '0;
  logic [11:0] lbl_addr;
  logic [15:0] lbl_base = '0;
  logic [15:0] lbl_size = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;

  int checks = 0;
  int fails = 0;

  logic [15:0] base_tab [4096];
  logic [15:0] size_tab [4096];

  int          obs_lat, obs_mcyc, obs_rsp;
  logic        obs_stable, obs_ready, obs_we;
  logic [11:0] obs_lbl;
  logic [15:0] obs_addr;
  logic [31:0] obs_wdata, obs_data;
  logic [1:0]  obs_fault;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    lbl_base <= base_tab[lbl_addr];
    lbl_size <= size_tab[lbl_addr];
  end

  ptr_access_unit #(.LBID_W(12), .OFS_W(16), .DATA_W(32), .TMO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lbid  (req_lbid),
    .req_ofs   (req_ofs),
    .req_wdata (req_wdata),
    .lbl_addr  (lbl_addr),
    .lbl_base  (lbl_base),
    .lbl_size  (lbl_size),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault)
  );

  // Issues one request and observes a fixed 12-cycle window; ack_on = MEM cycle to ack (0 = never).
  task automatic do_access(input logic we, input logic [11:0] lbid, input logic [15:0] ofs,
                           input logic [31:0] wdata, input int ack_on, input logic [31:0] rdata,
                           input logic stray);
    obs_lat = -1; obs_mcyc = 0; obs_rsp = 0; obs_stable = 1'b1;
    obs_addr = '0; obs_we = 1'b0; obs_wdata = '0; obs_data = '0; obs_fault = '0; obs_lbl = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_lbid = lbid; req_ofs = ofs; req_wdata = wdata;
    obs_ready = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_lbid = '1; req_ofs = '1; req_wdata = '1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) obs_lbl = lbl_addr;
      if (mem_req) begin
        obs_mcyc++;
        if (obs_mcyc > 1 && (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata))
          obs_stable = 1'b0;
        obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
        mem_ack = (obs_mcyc == ack_on);
        mem_rdata = rdata;
      end else begin
        mem_ack = stray;
        mem_rdata = 32'hBAD0BAD0;
      end
      if (rsp_valid) begin
        obs_rsp++;
        if (obs_lat < 0) begin obs_lat = c; obs_data = rsp_data; obs_fault = rsp_fault; end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({mem_we, mem_addr, mem_wdata, lbl_addr} !== '0) begin fails++; $display("FAIL rst_mem_outs: got %b/%h/%h/%h expected all 0", mem_we, mem_addr, mem_wdata, lbl_addr); end
    checks++; if ({rsp_data, rsp_fault} !== '0) begin fails++; $display("FAIL rst_rsp_outs: got %h/%0d expected 0/0", rsp_data, rsp_fault); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_load;
    do_access(1'b0, 12'd5, 16'd3, 32'h55, 2, 32'hDEADBEEF, 1'b0);
    checks++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL load_ready: got %b expected 1", obs_ready); end
    checks++; if (obs_lbl !== 12'd5) begin fails++; $display("FAIL load_lbl_addr: got %h expected 005", obs_lbl); end
    checks++; if (obs_mcyc != 2) begin fails++; $display("FAIL load_mem_cycles: got %0d expected 2", obs_mcyc); end
    checks++; if (obs_addr !== 16'h1003) begin fails++; $display("FAIL load_addr: got %h expected 1003", obs_addr); end
    checks++; if (obs_we !== 1'b0) begin fails++; $display("FAIL load_we: got %b expected 0", obs_we); end
    checks++; if (obs_stable !== 1'b1) begin fails++; $display("FAIL load_stable: got %b expected 1", obs_stable); end
    checks++; if (obs_data !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: got %h expected deadbeef", obs_data); end
    checks++; if (obs_fault !== 2'd0) begin fails++; $display("FAIL load_fault: got %0d expected 0", obs_fault); end
    checks++; if (obs_lat != 5) begin fails++; $display("FAIL load_latency: got %0d expected 5", obs_lat); end
    checks++; if (obs_rsp != 1) begin fails++; $display("FAIL load_rsp_count: got %0d expected 1", obs_rsp); end
    do_access(1'b0, 12'd5, 16'd0, 32'h0, 1, 32'hCAFEF00D, 1'b1);
    checks++; if (obs_addr !== 16'h1000) begin fails++; $display("FAIL stray_addr: got %h expected 1000", obs_addr); end
    checks++; if (obs_mcyc != 1) begin fails++; $display("FAIL stray_mem_cycles: got %0d expected 1", obs_mcyc); end
    checks++; if (obs_data !== 32'hCAFEF00D) begin fails++; $display("FAIL stray_data: got %h expected cafef00d", obs_data); end
    checks++; if (obs_lat != 4) begin fails++; $display("FAIL stray_latency: got %0d expected 4", obs_lat); end
  endtask

  task automatic test_store;
    do_access(1'b1, 12'd6, 16'd15, 32'd7, 1, 32'h12345678, 1'b0);
    checks++; if (obs_addr !== 16'h002F) begin fails++; $display("FAIL store_addr: got %h expected 002f", obs_addr); end
    checks++; if (obs_we !== 1'b1) begin fails++; $display("FAIL store_we: got %b expected 1", obs_we); end
    checks++; if (obs_wdata !== 32'd7) begin fails++; $display("FAIL store_wdata: got %h expected 00000007", obs_wdata); end
    checks++; if (obs_data !== 32'd0) begin fails++; $display("FAIL store_data: got %h expected 00000000", obs_data); end
    checks++; if (obs_fault !== 2'd0) begin fails++; $display("FAIL store_fault: got %0d expected 0", obs_fault); end
    checks++; if (obs_lat != 4) begin fails++; $display("FAIL store_latency: got %0d expected 4", obs_lat); end
  endtask

  task automatic test_bounds;
    do_access(1'b0, 12'd5, 16'd16, 32'h0, 1, 32'h11111111, 1'b0);
    checks++; if (obs_fault !== 2'd1) begin fails++; $display("FAIL oob_fault: got %0d expected 1", obs_fault); end
    checks++; if (obs_mcyc != 0) begin fails++; $display("FAIL oob_mem_req: got %0d cycles expected 0", obs_mcyc); end
    checks++; if (obs_lat != 3) begin fails++; $display("FAIL oob_latency: got %0d expected 3", obs_lat); end
    checks++; if (obs_data !== 32'd0) begin fails++; $display("FAIL oob_data: got %h expected 00000000", obs_data); end
    do_access(1'b0, 12'd8, 16'd0, 32'h0, 1, 32'h11111111, 1'b0);
    checks++; if (obs_fault !== 2'd1) begin fails++; $display("FAIL size0_fault: got %0d expected 1", obs_fault); end
    checks++; if (obs_mcyc != 0) begin fails++; $display("FAIL size0_mem_req: got %0d cycles expected 0", obs_mcyc); end
    checks++; if (obs_lat != 3) begin fails++; $display("FAIL size0_latency: got %0d expected 3", obs_lat); end
    checks++; if (obs_rsp != 1) begin fails++; $display("FAIL size0_rsp_count: got %0d expected 1", obs_rsp); end
  endtask

  task automatic test_overflow;
    do_access(1'b0, 12'd9, 16'h0020, 32'h0, 1, 32'h22222222, 1'b0);
    checks++; if (obs_fault !== 2'd2) begin fails++; $display("FAIL ovf_fault: got %0d expected 2", obs_fault); end
    checks++; if (obs_mcyc != 0) begin fails++; $display("FAIL ovf_mem_req: got %0d cycles expected 0", obs_mcyc); end
    checks++; if (obs_lat != 3) begin fails++; $display("FAIL ovf_latency: got %0d expected 3", obs_lat); end
  endtask

  task automatic test_timeout;
    do_access(1'b0, 12'd10, 16'd2, 32'h0, 0, 32'h33333333, 1'b0);
    checks++; if (obs_mcyc != 4) begin fails++; $display("FAIL tmo_mem_cycles: got %0d expected 4", obs_mcyc); end
    checks++; if (obs_fault !== 2'd3) begin fails++; $display("FAIL tmo_fault: got %0d expected 3", obs_fault); end
    checks++; if (obs_rsp != 1) begin fails++; $display("FAIL tmo_rsp_count: got %0d expected 1", obs_rsp); end
    checks++; if (obs_lat != 7) begin fails++; $display("FAIL tmo_latency: got %0d expected 7", obs_lat); end
    checks++; if (obs_data !== 32'd0) begin fails++; $display("FAIL tmo_data: got %h expected 00000000", obs_data); end
    do_access(1'b0, 12'd10, 16'd2, 32'h0, 4, 32'hA5A5A5A5, 1'b0);
    checks++; if (obs_fault !== 2'd0) begin fails++; $display("FAIL late_ack_fault: got %0d expected 0", obs_fault); end
    checks++; if (obs_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL late_ack_data: got %h expected a5a5a5a5", obs_data); end
    checks++; if (obs_lat != 7) begin fails++; $display("FAIL late_ack_latency: got %0d expected 7", obs_lat); end
    checks++; if (obs_addr !== 16'h0302) begin fails++; $display("FAIL late_ack_addr: got %h expected 0302", obs_addr); end
  endtask

  task automatic test_reset_mid;
    int rsp_seen;
    rsp_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_lbid = 12'd10; req_ofs = 16'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mid_in_mem: got %b expected 1", mem_req); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mid_mem_req: got %b expected 0", mem_req); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    checks++; if (rsp_seen != 0) begin fails++; $display("FAIL mid_rsp_valid: got %0d pulses expected 0", rsp_seen); end
    do_access(1'b0, 12'd5, 16'd4, 32'h0, 1, 32'h0BADCAFE, 1'b0);
    checks++; if (obs_addr !== 16'h1004) begin fails++; $display("FAIL after_rst_addr: got %h expected 1004", obs_addr); end
    checks++; if (obs_data !== 32'h0BADCAFE) begin fails++; $display("FAIL after_rst_data: got %h expected 0badcafe", obs_data); end
    checks++; if (obs_lat != 4) begin fails++; $display("FAIL after_rst_latency: got %0d expected 4", obs_lat); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] rdy, rsp;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_lbid = 12'd8; req_ofs = 16'd0;
    for (int c = 0; c < 9; c++) begin
      rdy[c] = req_ready;
      rsp[c] = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (rdy !== 9'b100010001) begin fails++; $display("FAIL b2b_ready: got %b expected 100010001", rdy); end
    checks++; if (rsp !== 9'b010001000) begin fails++; $display("FAIL b2b_rsp_valid: got %b expected 010001000", rsp); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin base_tab[i] = '0; size_tab[i] = '0; end
    base_tab[5]  = 16'h1000; size_tab[5]  = 16'd16;
    base_tab[6]  = 16'h0020; size_tab[6]  = 16'd16;
    base_tab[8]  = 16'h0100; size_tab[8]  = 16'd0;
    base_tab[9]  = 16'hFFF0; size_tab[9]  = 16'h0100;
    base_tab[10] = 16'h0300; size_tab[10] = 16'd8;
    test_reset;
    test_load;
    test_store;
    test_bounds;
    test_overflow;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
